// File: rtl/commit_prf_release_pkg.sv
// Shared rename/commit-unit parameters and small types.
//   RCU_PRF_ADDR_WIDTH    : physical register index width
//   RCU_FL_DATA_WIDTH     : freelist data width (same as the PRF index width)
//   RCU_QUEUE_DEPTH       : release staging queue entries
//   RCU_QUEUE_DEPTH_WIDTH : log2(RCU_QUEUE_DEPTH)
//   cnt_mode_e            : step selector for configurable_2mode_counter
package commit_prf_release_pkg;

    localparam int RCU_PRF_ADDR_WIDTH    = 5;
    localparam int RCU_FL_DATA_WIDTH     = RCU_PRF_ADDR_WIDTH;
    localparam int RCU_QUEUE_DEPTH       = 4;
    localparam int RCU_QUEUE_DEPTH_WIDTH = 2;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC1 = 2'd1,
        CNT_INC2 = 2'd2
    } cnt_mode_e;

endpackage

// File: rtl/commit_prf_release_if.sv
// Retire-side and freelist-side bus of the commit PRF release block.
// Ports (all carried as interface signals):
//   retire_{first,second}_{vld,rd_en,old_prd}_i : ROB retire pair
//   retire_ready_o                              : pair may be accepted
//   fl_full_i / fl_almost_full_i                : freelist occupancy flags
//   fl_wr_{first,second}_en_o, fl_wdata_*_o     : freelist write port pair
//
// Handshake: a retire pair transfers on a rising clk edge when any
// retire_*_vld_i is 1 and retire_ready_o is 1. retire_ready_o depends only on
// registered state. A valid pair presented while retire_ready_o is 0 is not
// stalled: it is dropped and flagged as an overflow. The freelist side has no
// ready: fl_wr_*_en_o are only raised when the flags allow the write.
interface commit_prf_release_if
    import commit_prf_release_pkg::*;
#(
    parameter int PRF_ADDR_WIDTH = RCU_PRF_ADDR_WIDTH
);
    logic                      retire_first_vld_i;
    logic                      retire_second_vld_i;
    logic                      retire_first_rd_en_i;
    logic                      retire_second_rd_en_i;
    logic [PRF_ADDR_WIDTH-1:0] retire_first_old_prd_i;
    logic [PRF_ADDR_WIDTH-1:0] retire_second_old_prd_i;
    logic                      retire_ready_o;
    logic                      fl_full_i;
    logic                      fl_almost_full_i;
    logic                      fl_wr_first_en_o;
    logic                      fl_wr_second_en_o;
    logic [PRF_ADDR_WIDTH-1:0] fl_wdata_first_o;
    logic [PRF_ADDR_WIDTH-1:0] fl_wdata_second_o;

    // Release block view.
    modport slave (
        input  retire_first_vld_i, retire_second_vld_i,
        input  retire_first_rd_en_i, retire_second_rd_en_i,
        input  retire_first_old_prd_i, retire_second_old_prd_i,
        output retire_ready_o,
        input  fl_full_i, fl_almost_full_i,
        output fl_wr_first_en_o, fl_wr_second_en_o,
        output fl_wdata_first_o, fl_wdata_second_o
    );

    // ROB + freelist view.
    modport master (
        output retire_first_vld_i, retire_second_vld_i,
        output retire_first_rd_en_i, retire_second_rd_en_i,
        output retire_first_old_prd_i, retire_second_old_prd_i,
        input  retire_ready_o,
        output fl_full_i, fl_almost_full_i,
        input  fl_wr_first_en_o, fl_wr_second_en_o,
        input  fl_wdata_first_o, fl_wdata_second_o
    );
endinterface

// File: rtl/configurable_2mode_counter.sv
// Wrapping pointer counter that steps by 0, +1 or +2 per cycle.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (value returns to 0)
//   mode_i     : CNT_HOLD / CNT_INC1 / CNT_INC2
//   value_o    : current count, wraps modulo 2**WIDTH
module configurable_2mode_counter
    import commit_prf_release_pkg::*;
#(
    parameter int WIDTH = RCU_QUEUE_DEPTH_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  cnt_mode_e        mode_i,
    output logic [WIDTH-1:0] value_o
);
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        case (mode_i)
            CNT_INC1: value_d = value_q + WIDTH'(1);
            CNT_INC2: value_d = value_q + WIDTH'(2);
            default:  value_d = value_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
endmodule

// File: rtl/commit_prf_release.sv
// Commit-time release of superseded physical registers to the freelist.
// Up to two retiring instructions per cycle hand in their old prd; the
// qualifying ones are compacted into a small staging FIFO, which drains up to
// two entries per cycle into the freelist as its full flags allow.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   rel_if            : retire pair in, freelist write pair out (slave view)
//   release_pending_o : staging queue occupancy
//   overflow_err_o    : sticky, a retire pair arrived while not ready
module commit_prf_release
    import commit_prf_release_pkg::*;
#(
    parameter int PRF_ADDR_WIDTH    = RCU_PRF_ADDR_WIDTH,
    parameter int QUEUE_DEPTH       = RCU_QUEUE_DEPTH,
    parameter int QUEUE_DEPTH_WIDTH = RCU_QUEUE_DEPTH_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    commit_prf_release_if.slave        rel_if,
    output logic [QUEUE_DEPTH_WIDTH:0] release_pending_o,
    output logic                       overflow_err_o
);
    localparam int OCC_W = QUEUE_DEPTH_WIDTH + 1;

    logic [PRF_ADDR_WIDTH-1:0]    entries_q [QUEUE_DEPTH];
    logic [OCC_W-1:0]             occ_q, occ_d;
    logic                         ovf_q, ovf_d;
    logic [QUEUE_DEPTH_WIDTH-1:0] head, tail;
    logic [QUEUE_DEPTH_WIDTH-1:0] head_next, tail_second;

    logic       ready;
    logic       retire_any;
    logic       qual_first, qual_second;
    logic       enq_first, enq_second;
    logic [1:0] enq_cnt, drain_cnt;

    // p0 is the hardwired zero register and is never returned to the freelist.
    assign qual_first  = rel_if.retire_first_vld_i & rel_if.retire_first_rd_en_i
                       & (|rel_if.retire_first_old_prd_i);
    assign qual_second = rel_if.retire_second_vld_i & rel_if.retire_second_rd_en_i
                       & (|rel_if.retire_second_old_prd_i);

    // Room for a full pair is guaranteed without counting on this cycle's drain,
    // which keeps ready free of any input dependence.
    assign ready      = (occ_q <= OCC_W'(QUEUE_DEPTH - 2));
    assign retire_any = rel_if.retire_first_vld_i | rel_if.retire_second_vld_i;
    assign enq_first  = retire_any & ready & qual_first;
    assign enq_second = retire_any & ready & qual_second;
    assign enq_cnt    = {1'b0, enq_first} + {1'b0, enq_second};

    always_comb begin
        drain_cnt = 2'd0;
        if (rel_if.fl_full_i) begin
            drain_cnt = 2'd0;
        end else if (rel_if.fl_almost_full_i) begin
            drain_cnt = (occ_q != '0) ? 2'd1 : 2'd0;
        end else if (occ_q >= OCC_W'(2)) begin
            drain_cnt = 2'd2;
        end else begin
            drain_cnt = occ_q[1:0];
        end
    end

    configurable_2mode_counter #(.WIDTH(QUEUE_DEPTH_WIDTH)) u_head_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode_i  (cnt_mode_e'(drain_cnt)),
        .value_o (head)
    );

    configurable_2mode_counter #(.WIDTH(QUEUE_DEPTH_WIDTH)) u_tail_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode_i  (cnt_mode_e'(enq_cnt)),
        .value_o (tail)
    );

    // Compaction: a lone qualifying second slot lands at tail, not tail+1.
    assign head_next   = head + QUEUE_DEPTH_WIDTH'(1);
    assign tail_second = enq_first ? tail + QUEUE_DEPTH_WIDTH'(1) : tail;

    assign occ_d = occ_q + OCC_W'(enq_cnt) - OCC_W'(drain_cnt);
    assign ovf_d = ovf_q | (retire_any & ~ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            ovf_q <= ovf_d;
        end
    end

    // Payload storage needs no reset: it is only read under a nonzero occupancy.
    always_ff @(posedge clk) begin
        if (enq_first) begin
            entries_q[tail] <= rel_if.retire_first_old_prd_i;
        end
        if (enq_second) begin
            entries_q[tail_second] <= rel_if.retire_second_old_prd_i;
        end
    end

    assign rel_if.retire_ready_o    = ready;
    assign rel_if.fl_wr_first_en_o  = (drain_cnt != 2'd0);
    assign rel_if.fl_wr_second_en_o = (drain_cnt == 2'd2);
    assign rel_if.fl_wdata_first_o  = (drain_cnt != 2'd0) ? entries_q[head] : '0;
    assign rel_if.fl_wdata_second_o = (drain_cnt == 2'd2) ? entries_q[head_next] : '0;

    assign release_pending_o = occ_q;
    assign overflow_err_o    = ovf_q;
endmodule

// File: doc/commit_prf_release.md
COMMIT_PRF_RELEASE -- requirements
Module: commit_prf_release

Interface
REQ-001 SHALL have parameter PRF_ADDR_WIDTH, default 5, physical register index width (equals freelist data width).
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, staging queue entries; QUEUE_DEPTH_WIDTH, default 2, log2(QUEUE_DEPTH).
REQ-003 SHALL use one clock and a synchronous, active-low reset, with the following ports.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 retire_first_vld_i / retire_second_vld_i  in  1 each  ROB retire slot valid.
REQ-007 retire_first_rd_en_i / retire_second_rd_en_i  in  1 each  retiring instruction wrote an rd.
REQ-008 retire_first_old_prd_i / retire_second_old_prd_i  in  PRF_ADDR_WIDTH each  superseded physical register to free.
REQ-009 retire_ready_o  out  1  retire pair may be accepted this cycle.
REQ-010 fl_full_i / fl_almost_full_i  in  1 each  freelist occupancy flags.
REQ-011 fl_wr_first_en_o / fl_wr_second_en_o  out  1 each  freelist write enables.
REQ-012 fl_wdata_first_o / fl_wdata_second_o  out  PRF_ADDR_WIDTH each  freelist write data.
REQ-013 release_pending_o  out  QUEUE_DEPTH_WIDTH+1  staging queue occupancy.
REQ-014 overflow_err_o  out  1  sticky: retire presented while not ready.

Function
REQ-015 Slot qualifies for release only if vld & rd_en & old_prd != 0 (p0 never freed).
REQ-016 Pair accepted when retire_ready_o=1; qualifying slots enqueue in order first then second, compacted (only second qualifying -> occupies one entry).
REQ-017 retire_ready_o SHALL equal (release_pending_o <= QUEUE_DEPTH-2), from registered state only, no combinational path from any input.
REQ-018 Drain count per cycle: 0 if fl_full_i; else 1 if fl_almost_full_i; else min(occupancy, 2).
REQ-019 fl_wr_first_en_o=1 iff drain>=1, data = head entry; fl_wr_second_en_o=1 iff drain==2, data = head+1 entry.
REQ-020 fl_wr_second_en_o SHALL never assert without fl_wr_first_en_o.
REQ-021 fl_wdata_*_o SHALL be 0 when the matching enable is 0.
REQ-022 Enqueue and drain in same cycle both take effect; occupancy_next = occupancy + enq - drain.
REQ-023 Latency: entry accepted at edge N is presented on fl_wr_* from cycle N+1 at earliest; no bypass.
REQ-024 Head/tail pointers wrap modulo QUEUE_DEPTH; FIFO order preserved across wrap.
REQ-025 Any retire_*_vld_i=1 while retire_ready_o=0: pair dropped, overflow_err_o set and held until reset.
REQ-026 Retired entries are architecturally committed: no flush input; queue always drains to freelist.

Reset
REQ-027 rst_n=0 at an edge: occupancy 0, pointers 0, overflow_err_o 0; retire_ready_o=1, all fl_wr_* outputs 0 next cycle.
REQ-028 Reset mid-operation discards queued entries (freelist re-initialised by the same reset).

Structure
REQ-029 PRF_ADDR_WIDTH and QUEUE_DEPTH constants SHALL live in the shared rcu parameter package with freelist widths.
REQ-030 Pointer arithmetic SHALL reuse configurable_2mode_counter (modes 0/+1/+2) for head and tail; no other sub-module.

Verification
REQ-031 Pair (vld,rd_en,prd)=(1,1,7),(1,1,9), flags 0 -> next cycle fl_wr_first=7, fl_wr_second=9, both enables 1.
REQ-032 First old_prd=0, second (1,1,12) -> single entry; next cycle fl_wr_first_en=1 data 12, second_en=0.
REQ-033 fl_full_i=1 for 3 cycles with 2 pairs retired -> occupancy 4, retire_ready_o=0; release fl_full_i -> 5,6 then 8,9 order over 2 cycles.
REQ-034 fl_almost_full_i=1, occupancy 3 -> exactly one write per cycle, 3 cycles to empty, order preserved.
REQ-035 Retire while retire_ready_o=0 -> overflow_err_o=1 sticky, occupancy unchanged; rst_n=0 clears it.
REQ-036 Continuous 20-cycle dual retire, flags 0, prd 1..31 sequence wrapping pointers -> freelist sees identical sequence, ready never drops.
